// File: rtl/uarttx_frame_pkg.sv
// Shared constants for the ASCII parameter frame "P" + amp(4) + freq(6) + CR + LF.
// The receive-side frame parser imports the same byte constants and state encodings.
package uarttx_frame_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'h50;
  localparam logic [7:0] CR_BYTE     = 8'h0D;
  localparam logic [7:0] LF_BYTE     = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int unsigned AMP_DIGITS  = 4;
  localparam int unsigned FREQ_DIGITS = 6;
  localparam logic [3:0]  LAST_IDX    = 4'd12;

  typedef enum logic [2:0] {
    StIdle,
    StConvAmp,
    StConvFreq,
    StLoad,
    StStrobe,
    StWaitAck,
    StWaitDone,
    StFinish
  } frame_state_e;

  typedef enum logic [1:0] {
    BcdIdle,
    BcdShift,
    BcdDone
  } bcd_state_e;

  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'b0000, digit};
  endfunction

endpackage

// File: rtl/uarttx_frame_bin2bcd_seq.sv
// Serial double-dabble: 20-bit binary to 6 BCD digits, one shift per cycle.
// start is honoured only when idle; done pulses one cycle after the 20th shift.
module uarttx_frame_bin2bcd_seq
  import uarttx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] bin,
  output logic        done,
  output logic [23:0] bcd
);

  bcd_state_e  state_q;
  logic [19:0] bin_q;
  logic [23:0] bcd_q;
  logic [23:0] bcd_adj;
  logic [4:0]  cnt_q;

  // Add-3 correction on every digit that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[i*4 +: 4] > 4'd4) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BcdIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        BcdIdle: begin
          done <= 1'b0;
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= BcdShift;
          end
        end
        BcdShift: begin
          bcd_q <= {bcd_adj[22:0], bin_q[19]};
          bin_q <= {bin_q[18:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd19) begin
            done    <= 1'b1;
            state_q <= BcdDone;
          end
        end
        BcdDone: begin
          done    <= 1'b0;
          state_q <= BcdIdle;
        end
        default: begin
          done    <= 1'b0;
          state_q <= BcdIdle;
        end
      endcase
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/uarttx_frame.sv
// Builds the 13-byte "P" + amp + freq + CR + LF frame and hands it byte by byte
// to the UART byte transmitter over the wrsig/tx_busy handshake.
module uarttx_frame
  import uarttx_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER   = HEADER_BYTE,
  parameter int unsigned AMP_MAX  = 9999,
  parameter int unsigned FREQ_MAX = 999999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] freq_in,
  input  logic [16:0] amp_in,
  input  logic        send,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        wrsig,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  frame_state_e state_q;
  logic [3:0]   idx_q;
  logic [15:0]  amp_bcd_q;
  logic [23:0]  freq_bcd_q;
  logic [19:0]  freq_lat_q;
  logic [19:0]  conv_bin_q;
  logic         conv_start_q;
  logic         conv_done;
  logic [23:0]  conv_bcd;

  logic         amp_over;
  logic         freq_over;
  logic [19:0]  amp_clamp;
  logic [19:0]  freq_clamp;
  logic [7:0]   frame_byte;

  always_comb begin
    amp_over   = 32'(amp_in) >= AMP_MAX;
    freq_over  = 32'(freq_in) >= FREQ_MAX;
    amp_clamp  = amp_over ? 20'(AMP_MAX) : {3'b000, amp_in};
    freq_clamp = freq_over ? 20'(FREQ_MAX) : {3'b000, freq_in};
  end

  always_comb begin
    frame_byte = HEADER;
    case (idx_q)
      4'd0:    frame_byte = HEADER;
      4'd1:    frame_byte = digit_ascii(amp_bcd_q[15:12]);
      4'd2:    frame_byte = digit_ascii(amp_bcd_q[11:8]);
      4'd3:    frame_byte = digit_ascii(amp_bcd_q[7:4]);
      4'd4:    frame_byte = digit_ascii(amp_bcd_q[3:0]);
      4'd5:    frame_byte = digit_ascii(freq_bcd_q[23:20]);
      4'd6:    frame_byte = digit_ascii(freq_bcd_q[19:16]);
      4'd7:    frame_byte = digit_ascii(freq_bcd_q[15:12]);
      4'd8:    frame_byte = digit_ascii(freq_bcd_q[11:8]);
      4'd9:    frame_byte = digit_ascii(freq_bcd_q[7:4]);
      4'd10:   frame_byte = digit_ascii(freq_bcd_q[3:0]);
      4'd11:   frame_byte = CR_BYTE;
      4'd12:   frame_byte = LF_BYTE;
      default: frame_byte = HEADER;
    endcase
  end

  uarttx_frame_bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start_q),
    .bin   (conv_bin_q),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      amp_bcd_q    <= '0;
      freq_bcd_q   <= '0;
      freq_lat_q   <= '0;
      conv_bin_q   <= '0;
      conv_start_q <= 1'b0;
      tx_data      <= '0;
      wrsig        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done  <= 1'b0;
          wrsig <= 1'b0;
          if (send && !tx_busy) begin
            conv_bin_q   <= amp_clamp;
            freq_lat_q   <= freq_clamp;
            sat          <= amp_over | freq_over;
            busy         <= 1'b1;
            conv_start_q <= 1'b1;
            state_q      <= StConvAmp;
          end
        end
        StConvAmp: begin
          conv_start_q <= 1'b0;
          if (conv_done) begin
            amp_bcd_q    <= conv_bcd[15:0];
            conv_bin_q   <= freq_lat_q;
            conv_start_q <= 1'b1;
            state_q      <= StConvFreq;
          end
        end
        StConvFreq: begin
          conv_start_q <= 1'b0;
          if (conv_done) begin
            freq_bcd_q <= conv_bcd;
            idx_q      <= '0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          // Byte and strobe launch together, so tx_data is valid for the whole strobe.
          if (!tx_busy) begin
            tx_data <= frame_byte;
            wrsig   <= 1'b1;
            state_q <= StStrobe;
          end
        end
        StStrobe: begin
          wrsig   <= 1'b0;
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StLoad;
            end
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uarttx_frame.sv
// Directed bench for uarttx_frame with a byte-transmitter model and a loopback frame parser.
module tb_uarttx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic        tx_busy = 1'b0;
  logic [16:0] freq_in = '0;
  logic [16:0] amp_in = '0;
  logic [7:0]  tx_data;
  logic        wrsig;
  logic        busy;
  logic        done;
  logic        sat;

  localparam int BYTE_CYC = 10;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobes = 0;
  int dones = 0;
  int wr_busy_bad = 0;
  int first_wr_cyc = 0;
  int accept_cyc = 0;
  int busy_cnt = 0;
  bit hold = 1'b0;
  logic [7:0] captured[$];

  always #5 clk = ~clk;

  uarttx_frame dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .freq_in (freq_in),
    .amp_in  (amp_in),
    .send    (send),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .wrsig   (wrsig),
    .busy    (busy),
    .done    (done),
    .sat     (sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte transmitter model: busy for BYTE_CYC cycles after each strobe.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (wrsig) begin
          if (tx_busy) wr_busy_bad++;
          captured.push_back(tx_data);
          strobes++;
          if (strobes == 1) first_wr_cyc = cyc;
          busy_cnt = BYTE_CYC;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        if (done) dones++;
      end
      tx_busy = hold || (busy_cnt > 0);
    end
  end

  task automatic send_frame(input logic [16:0] a, input logic [16:0] f);
    @(posedge clk);
    #2;
    amp_in = a;
    freq_in = f;
    captured.delete();
    strobes = 0;
    dones = 0;
    wr_busy_bad = 0;
    first_wr_cyc = 0;
    send = 1'b1;
    accept_cyc = cyc + 1;
    @(posedge clk);
    #2;
    send = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("done_seen", 32'(dones > 0), 1);
  endtask

  task automatic wait_bytes(input int nbytes, input int budget);
    int n = 0;
    while (captured.size() < nbytes && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("bytes_reached", 32'(captured.size() >= nbytes), 1);
  endtask

  // Receive-side parser model: header, ten ASCII digits, CR, LF.
  task automatic parse_frame(output bit ok, output int pa, output int pf);
    logic [7:0] c;
    ok = 1'b0;
    pa = 0;
    pf = 0;
    if (captured.size() == 13) begin
      ok = (captured[0] == 8'h50) && (captured[11] == 8'h0D) && (captured[12] == 8'h0A);
      for (int i = 1; i <= 10; i++) begin
        c = captured[i];
        if (c < 8'h30 || c > 8'h39) ok = 1'b0;
        if (i <= 4) pa = pa * 10 + int'(c - 8'h30);
        else        pf = pf * 10 + int'(c - 8'h30);
      end
    end
  endtask

  task automatic check_frame(input string exp, input bit exp_sat, input int ea, input int ef);
    logic [7:0] got;
    logic [7:0] want;
    bit ok;
    int pa;
    int pf;
    check_eq("frame_len", captured.size(), 13);
    for (int i = 0; i < 13; i++) begin
      got = (i < captured.size()) ? captured[i] : 8'h00;
      if (i < 11)       want = exp[i];
      else if (i == 11) want = 8'h0D;
      else              want = 8'h0A;
      check_eq($sformatf("byte%0d", i), got, want);
    end
    check_eq("strobes", strobes, 13);
    check_eq("done_pulses", dones, 1);
    check_eq("sat", sat, exp_sat);
    check_eq("busy_after_done", busy, 0);
    check_eq("wrsig_while_busy", wr_busy_bad, 0);
    parse_frame(ok, pa, pf);
    check_eq("parse_ok", ok, 1);
    check_eq("parse_amp", pa, ea);
    check_eq("parse_freq", pf, ef);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_wrsig", wrsig, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sat", sat, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Leading zeros kept
    send_frame(17'd20, 17'd100);
    check_eq("busy_after_accept", busy, 1);
    wait_done(2000);
    check_frame("P0020000100", 1'b0, 20, 100);
    check_eq("first_wr_latency", 32'((first_wr_cyc - accept_cyc) <= 47 && first_wr_cyc > 0), 1);

    // amp clamps, freq at 17-bit maximum passes through
    send_frame(17'd12345, 17'd131071);
    wait_done(2000);
    check_frame("P9999131071", 1'b1, 9999, 131071);

    // Repeated send with new inputs mid-frame is ignored
    send_frame(17'd7, 17'd42);
    repeat (60) @(posedge clk);
    #2;
    amp_in = 17'd1111;
    freq_in = 17'd2222;
    send = 1'b1;
    @(posedge clk);
    #2;
    send = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    send = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    send = 1'b0;
    wait_done(2000);
    check_frame("P0007000042", 1'b0, 7, 42);
    repeat (80) @(posedge clk);
    #2;
    check_eq("no_extra_strobes", strobes, 13);
    check_eq("idle_after_frame", busy, 0);

    // Transmitter stalls for 500 cycles after byte 5
    send_frame(17'd4321, 17'd98765);
    wait_bytes(5, 2000);
    hold = 1'b1;
    repeat (500) @(posedge clk);
    #2;
    check_eq("hold_no_wrsig", strobes, 5);
    hold = 1'b0;
    wait_done(3000);
    check_frame("P4321098765", 1'b0, 4321, 98765);

    // Asynchronous reset during byte 7
    send_frame(17'd10000, 17'd66);
    wait_bytes(8, 2000);
    check_eq("sat_before_reset", sat, 1);
    check_eq("busy_before_reset", busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx_data", tx_data, 0);
    check_eq("arst_wrsig", wrsig, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_sat", sat, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check_eq("no_done_after_abort", dones, 0);
    check_eq("no_bytes_after_abort", strobes, 8);

    // Exact saturation boundary, then all zeros
    send_frame(17'd9999, 17'd0);
    wait_done(2000);
    check_frame("P9999000000", 1'b1, 9999, 0);
    send_frame(17'd0, 17'd0);
    wait_done(2000);
    check_frame("P0000000000", 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
